md_sched: RTL and testbench
===========================

Name: md_sched

Overview:
- Sequencer for the shared multiply/divide resource and the HI/LO register pair in the 5-stage MIPS pipeline.
- Sits in the E stage. It is fed by the op/func fields from the instruction decoder and by forwarded rs/rt operand values.
- Launches multi-cycle MULT/MULTU/DIV/DIVU, handles MTHI/MTLO writes and MFHI/MFLO reads, and requests a pipeline stall while the unit is occupied.

Parameters:
- MULT_CYCLES, 5, busy duration for MULT/MULTU; legal range 1..255.
- DIV_CYCLES, 10, busy duration for DIV/DIVU; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_e  input  1  E-stage instruction is valid (not bubble, not flushed).
- op  input  6  opcode field of the E-stage instruction.
- func  input  6  function field of the E-stage instruction.
- rs_val  input  32  forwarded rs operand.
- rt_val  input  32  forwarded rt operand.
- start  output  1  combinational; a mul/div is launched this cycle.
- busy  output  1  registered; unit is computing.
- stall_req  output  1  combinational; hold F/D/E and insert a bubble into M.
- hi  output  32  current HI register.
- lo  output  32  current LO register.
- md_out  output  32  combinational; MFHI returns hi, MFLO returns lo, all other instructions return 0.

Behaviour:
- Decode: recognised only when op==6'h00. func codes:
  - 6'h18 MULT, 6'h19 MULTU, 6'h1A DIV, 6'h1B DIVU
  - 6'h10 MFHI, 6'h11 MTHI, 6'h12 MFLO, 6'h13 MTLO
  - is_md = any of these eight; is_op = the four mul/div codes.
- stall_req = valid_e & is_md & busy. When asserted, the instruction in E has no effect: no start, no HI/LO write. Its md_out value is don't-care.
- start = valid_e & is_op & ~busy.
- Timing of a launch at cycle T:
  - Result is computed from rs_val/rt_val sampled at the T edge and held in internal pending registers.
  - Counter loads MULT_CYCLES or DIV_CYCLES.
  - busy is high for cycles T+1 .. T+N.
  - At the end of cycle T+N the pending value commits to HI/LO. busy drops, and the new HI/LO are visible from T+N+1.
- Counter decrements every cycle while busy. Commit and busy clear happen on the edge where counter==1.
- A new start can occur in cycle T+N+1 at the earliest. There is no back-to-back overlap.
- MTHI/MTLO with valid_e & ~busy: write rs_val to HI or LO at the clock edge. The other register is unchanged.
- MFHI/MFLO with valid_e & ~busy: md_out presents hi or lo in the same cycle (zero latency).
- Arithmetic:
  - MULT: signed 32x32 -> 64-bit product; HI = [63:32], LO = [31:0].
  - MULTU: the same, unsigned.
  - DIV: signed. LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Boundary cases:
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - Divide by zero (DIV or DIVU): unit still goes busy for DIV_CYCLES; HI and LO keep their previous values at commit.
- Flush or valid_e deasserting while busy: has no effect on the in-flight operation. A launched operation always completes.
- Non-md instructions in E while busy: no stall, no effect.
- Reset, including mid-operation: hi = 0, lo = 0, busy = 0, counter = 0, pending result discarded. start, stall_req and md_out follow combinationally, so all three are 0 in the cycle after reset when valid_e = 0.
- Parameter values outside 1..255 are illegal; behaviour for them is undefined.

Test Plan:
- Reset, then MULT with rs = 0xFFFFFFFF, rt = 0x00000002 at T → start = 1 at T; busy = 1 for T+1..T+5; hi = 0xFFFFFFFF, lo = 0xFFFFFFFE from T+6.
- MULTU with the same operands → hi = 0x00000001, lo = 0xFFFFFFFE after 5 busy cycles. Then DIVU 7/2 → lo = 3, hi = 1 after 10 busy cycles.
- DIV with rs = 0xFFFFFFF9 (-7), rt = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- Following DIV, present MFLO in E during T+1..T+10 → stall_req = 1 for exactly 10 cycles. At T+11, stall_req = 0 and md_out = the new lo. An ADDU (func 6'h21) in E while busy → stall_req = 0.
- Preload with MTHI 0x12345678 and MTLO 0x9ABCDEF0, then DIVU x/0 → after 10 busy cycles hi = 0x12345678, lo = 0x9ABCDEF0 (unchanged). MTHI while busy → stall_req = 1 and hi is not written.
- Launch MULT, assert reset at T+3 → next cycle busy = 0, hi = lo = 0, and no commit ever occurs. A MULT issued immediately afterwards completes normally.

Source files
------------

// File: rtl/md_sched.sv
// E-stage sequencer for the shared multiply/divide unit and the HI/LO pair.
// Launches timed mul/div operations, serves MFxx/MTxx and stalls the pipe while busy.
module md_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_e,
    input  logic [5:0]  op,
    input  logic [5:0]  func,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        start,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] phi_q, phi_d, plo_q, plo_d;
    logic        pwr_q, pwr_d;

    logic        is_special, is_op, is_md, is_mul;
    logic [63:0] prod_s, prod_u;
    logic        num_neg, den_neg;
    logic [31:0] num_mag, den_mag, den_safe, quo_mag, rem_mag, quo, rem;

    // Decode
    assign is_special = (op == 6'h00);
    assign is_op = is_special &&
                   (func == F_MULT || func == F_MULTU || func == F_DIV || func == F_DIVU);
    assign is_md = is_op || (is_special &&
                   (func == F_MFHI || func == F_MTHI || func == F_MFLO || func == F_MTLO));
    assign is_mul = (func == F_MULT) || (func == F_MULTU);

    assign busy      = (state_q == S_BUSY);
    assign start     = valid_e & is_op & ~busy;
    assign stall_req = valid_e & is_md & busy;
    assign hi        = hi_q;
    assign lo        = lo_q;

    always_comb begin
        md_out = '0;
        if (valid_e && is_special) begin
            if (func == F_MFHI)      md_out = hi_q;
            else if (func == F_MFLO) md_out = lo_q;
        end
    end

    // Products
    assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign prod_u = {32'b0, rs_val} * {32'b0, rt_val};

    // Signed division on magnitudes so 0x80000000 / -1 needs no special case
    assign num_neg  = (func == F_DIV) & rs_val[31];
    assign den_neg  = (func == F_DIV) & rt_val[31];
    assign num_mag  = num_neg ? (32'd0 - rs_val) : rs_val;
    assign den_mag  = den_neg ? (32'd0 - rt_val) : rt_val;
    assign den_safe = (rt_val == 32'd0) ? 32'd1 : den_mag;
    assign quo_mag  = num_mag / den_safe;
    assign rem_mag  = num_mag % den_safe;
    assign quo      = (num_neg ^ den_neg) ? (32'd0 - quo_mag) : quo_mag;
    assign rem      = num_neg ? (32'd0 - rem_mag) : rem_mag;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        pwr_d   = pwr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_BUSY;
                    if (is_mul) begin
                        cnt_d = 8'(MULT_CYCLES);
                        phi_d = (func == F_MULTU) ? prod_u[63:32] : prod_s[63:32];
                        plo_d = (func == F_MULTU) ? prod_u[31:0]  : prod_s[31:0];
                        pwr_d = 1'b1;
                    end else begin
                        cnt_d = 8'(DIV_CYCLES);
                        phi_d = rem;
                        plo_d = quo;
                        // A zero divisor still occupies the unit but leaves HI/LO alone
                        pwr_d = (rt_val != 32'd0);
                    end
                end else if (valid_e && is_special) begin
                    if (func == F_MTHI)      hi_d = rs_val;
                    else if (func == F_MTLO) lo_d = rs_val;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = S_IDLE;
                    if (pwr_q) begin
                        hi_d = phi_q;
                        lo_d = plo_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            pwr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            pwr_q   <= pwr_d;
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed vector table, hand-written corner
// sequences and randomized traffic against an arithmetic reference model.
module tb_md_sched;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk, reset, valid_e;
    logic [5:0]  op, func;
    logic [31:0] rs_val, rt_val;
    logic        start, busy, stall_req;
    logic [31:0] hi, lo, md_out;

    md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .valid_e(valid_e), .op(op), .func(func),
        .rs_val(rs_val), .rt_val(rt_val), .start(start), .busy(busy),
        .stall_req(stall_req), .hi(hi), .lo(lo), .md_out(md_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: remaining busy cycles plus pending result
    int          mb;
    logic [31:0] mhi, mlo, ph, pl;
    bit          pw;

    logic        s_start, s_busy, s_stall;
    logic [31:0] s_hi, s_lo, s_md;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        longint a, b, p;
        longint unsigned ua, ub, up;
        if (reset) begin
            mb = 0; mhi = '0; mlo = '0; pw = 0;
        end else if (mb > 0) begin
            mb--;
            if (mb == 0 && pw) begin
                mhi = ph; mlo = pl;
            end
        end else if (valid_e && op == 6'h00) begin
            a  = longint'($signed(rs_val));
            b  = longint'($signed(rt_val));
            ua = {32'b0, rs_val};
            ub = {32'b0, rt_val};
            case (func)
                6'h18: begin p = a * b;   ph = p[63:32];  pl = p[31:0];  pw = 1; mb = MC; end
                6'h19: begin up = ua * ub; ph = up[63:32]; pl = up[31:0]; pw = 1; mb = MC; end
                6'h1A: begin
                    mb = DC; pw = (b != 0);
                    if (b != 0) begin
                        p = a / b; pl = p[31:0];
                        p = a % b; ph = p[31:0];
                    end
                end
                6'h1B: begin
                    mb = DC; pw = (ub != 0);
                    if (ub != 0) begin
                        up = ua / ub; pl = up[31:0];
                        up = ua % ub; ph = up[31:0];
                    end
                end
                6'h11: mhi = rs_val;
                6'h13: mlo = rs_val;
                default: ;
            endcase
        end
    endtask

    // Called at a falling edge with inputs already driven
    task automatic tick();
        bit mbusy, mis_op, mis_md, mstart, mstall;
        logic [31:0] mmd;
        #2;
        mbusy  = (mb > 0);
        mis_op = (op == 6'h00) && (func inside {6'h18, 6'h19, 6'h1A, 6'h1B});
        mis_md = mis_op || ((op == 6'h00) && (func inside {6'h10, 6'h11, 6'h12, 6'h13}));
        mstart = valid_e && mis_op && !mbusy;
        mstall = valid_e && mis_md && mbusy;
        mmd = '0;
        if (valid_e && op == 6'h00 && func == 6'h10) mmd = mhi;
        else if (valid_e && op == 6'h00 && func == 6'h12) mmd = mlo;
        s_start = start; s_busy = busy; s_stall = stall_req;
        s_hi = hi; s_lo = lo; s_md = md_out;
        chk("m_start", {31'b0, start}, {31'b0, mstart});
        chk("m_busy", {31'b0, busy}, {31'b0, mbusy});
        chk("m_stall", {31'b0, stall_req}, {31'b0, mstall});
        chk("m_hi", hi, mhi);
        chk("m_lo", lo, mlo);
        if (!mstall) chk("m_md_out", md_out, mmd);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_in(input logic v, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        valid_e = v; op = 6'h00; func = f; rs_val = a; rt_val = b;
    endtask

    task automatic drain();
        set_in(1'b0, 6'h00, '0, '0);
        for (int i = 0; i < 300 && busy; i++) tick();
        chk("drain_timeout", {31'b0, busy}, 32'd0);
    endtask

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        set_in(1'b1, f, a, b);
        tick();
        chk("launch_start", {31'b0, s_start}, 32'd1);
        set_in(1'b0, 6'h00, '0, '0);
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [5:0]  f;
        logic [31:0] rs, rt, exp_hi, exp_lo;
        int          n;
    } vec_t;

    vec_t vecs[8];
    logic [5:0] flist[10];
    int n;

    initial begin
        vecs[0] = '{6'h18, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MC};
        vecs[1] = '{6'h19, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, MC};
        vecs[2] = '{6'h1B, 32'd7,         32'd2,         32'd1,         32'd3,         DC};
        vecs[3] = '{6'h1A, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DC};
        vecs[4] = '{6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DC};
        vecs[5] = '{6'h18, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MC};
        vecs[6] = '{6'h1A, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DC};
        vecs[7] = '{6'h1B, 32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 32'h0FFF_FFFF, DC};
        flist = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h11, 6'h12, 6'h13, 6'h21, 6'h00};

        mb = 0; mhi = '0; mlo = '0; ph = '0; pl = '0; pw = 0;
        reset = 1'b1;
        set_in(1'b0, 6'h00, '0, '0);
        @(posedge clk);
        @(negedge clk);
        tick();
        reset = 1'b0;

        // Reset state
        tick();
        chk("rst_start", {31'b0, s_start}, 32'd0);
        chk("rst_busy", {31'b0, s_busy}, 32'd0);
        chk("rst_stall", {31'b0, s_stall}, 32'd0);
        chk("rst_hi", s_hi, 32'd0);
        chk("rst_lo", s_lo, 32'd0);
        chk("rst_md_out", s_md, 32'd0);

        // Vector table
        foreach (vecs[i]) begin
            run_op(vecs[i].f, vecs[i].rs, vecs[i].rt, n);
            chk($sformatf("vec%0d_cycles", i), 32'(n), 32'(vecs[i].n));
            chk($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
            chk($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
        end

        // MFLO held in E across a DIV: stalls exactly DC cycles, then reads new LO
        set_in(1'b1, 6'h1A, 32'd100, 32'd7);
        tick();
        set_in(1'b1, 6'h12, '0, '0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!s_stall) break;
            n++;
        end
        chk("mflo_stall_cycles", 32'(n), 32'(DC));
        chk("mflo_md_out", s_md, 32'd14);
        chk("mflo_hi", s_hi, 32'd2);

        // Non-md instruction while busy does not stall; a mul/div does and is ignored
        set_in(1'b1, 6'h18, 32'd6, 32'd7);
        tick();
        set_in(1'b1, 6'h21, 32'd1, 32'd1);
        tick();
        chk("addu_no_stall", {31'b0, s_stall}, 32'd0);
        chk("addu_busy", {31'b0, s_busy}, 32'd1);
        set_in(1'b1, 6'h19, 32'd9, 32'd9);
        tick();
        chk("op_busy_stall", {31'b0, s_stall}, 32'd1);
        chk("op_busy_no_start", {31'b0, s_start}, 32'd0);
        drain();
        chk("mult42_lo", lo, 32'd42);
        chk("mult42_hi", hi, 32'd0);

        // Divide by zero keeps HI/LO; MTHI while busy is stalled and dropped
        set_in(1'b1, 6'h11, 32'h1234_5678, '0);
        tick();
        set_in(1'b1, 6'h13, 32'h9ABC_DEF0, '0);
        tick();
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mtlo_lo", lo, 32'h9ABC_DEF0);
        set_in(1'b1, 6'h1B, 32'd5, 32'd0);
        tick();
        set_in(1'b1, 6'h11, 32'hDEAD_BEEF, '0);
        tick();
        chk("mthi_busy_stall", {31'b0, s_stall}, 32'd1);
        n = 1;
        set_in(1'b0, 6'h00, '0, '0);
        while (busy && n < 300) begin
            tick();
            n++;
        end
        chk("div0_cycles", 32'(n), 32'(DC));
        chk("div0_hi", hi, 32'h1234_5678);
        chk("div0_lo", lo, 32'h9ABC_DEF0);

        // Reset in the middle of a MULT: no commit ever lands
        set_in(1'b1, 6'h18, 32'd3, 32'd4);
        tick();
        set_in(1'b0, 6'h00, '0, '0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("midrst_busy", {31'b0, s_busy}, 32'd0);
        chk("midrst_hi", s_hi, 32'd0);
        chk("midrst_lo", s_lo, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        chk("midrst_no_commit_lo", lo, 32'd0);
        run_op(6'h18, 32'd3, 32'd4, n);
        chk("post_rst_cycles", 32'(n), 32'(MC));
        chk("post_rst_lo", lo, 32'd12);
        chk("post_rst_hi", hi, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset   = ($urandom_range(0, 199) == 0);
            valid_e = ($urandom_range(0, 9) < 7);
            op      = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'h00;
            func    = flist[$urandom_range(0, 9)];
            rs_val  = pick();
            rt_val  = pick();
            tick();
        end
        reset = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
